// File: rtl/seq_mult_signed_if.sv
// seq_mult_signed_if: start/busy/done handshake bundle; master = controller, slave = multiplier
interface seq_mult_signed_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 zflag;
    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product, zflag
    );
    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product, zflag
    );
endinterface

// File: rtl/seq_mult_signed.sv
// seq_mult_signed: iterative sign-magnitude shift-add multiplier; ports clk, rst_n (async low), bus (start/signed_mode/operands in, busy/done/product/zflag out)
module seq_mult_signed #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    seq_mult_signed_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    logic [1:0]         state;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic               neg;
    logic               done;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    // Magnitudes are unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1) without overflow
    always_comb begin
        a_mag = (bus.signed_mode & bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
        b_mag = (bus.signed_mode & bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    mplier <= b_mag;
                    mcand  <= {{WIDTH{1'b0}}, a_mag};
                    acc    <= '0;
                    neg    <= bus.signed_mode & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
                    state  <= RUN;
                end
                // Stops as soon as no multiplier bits remain, so latency tracks the bit length
                RUN: if (mplier == '0) begin
                    state <= SIGN;
                end else begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                end
                // Negating a zero accumulator yields zero, so there is no negative zero
                SIGN: begin
                    product <= neg ? -acc : acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy    = (state == RUN) || (state == SIGN);
    assign bus.done    = done;
    assign bus.product = product;
    assign bus.zflag   = (product == '0);
endmodule

// File: tb/tb_seq_mult_signed.sv
// tb_seq_mult_signed: directed self-checking bench for seq_mult_signed at WIDTH=8
module tb_seq_mult_signed;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    seq_mult_signed_if #(.WIDTH(W)) bus ();
    seq_mult_signed #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Drives one operation, scrambles the operand inputs after acceptance, and measures latency in edges
    task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2*W-1:0] p, output logic z, output logic bz);
        bus.signed_mode  = sm;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
        bus.signed_mode  = ~sm;
        lat = -1;
        bz  = 1'b1;
        for (int i = 1; i <= 2*W+8; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                if (bus.busy) bz = 1'b0;
                break;
            end
            if (!bus.busy) bz = 1'b0;
        end
        p = bus.product;
        z = bus.zflag;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus.product !== 16'h0000) begin n_bad++; $display("FAIL reset product: got %h want 0000", bus.product); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.zflag !== 1'b1) begin n_bad++; $display("FAIL reset zflag: got %b want 1", bus.zflag); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_signed_basic();
        int lat; logic [2*W-1:0] p; logic z, bz;
        run_op(1'b1, 8'hF9, 8'h05, lat, p, z, bz);
        n_cmp++; if (p !== 16'hFFDD) begin n_bad++; $display("FAIL m7x5 product: got %h want FFDD", p); end
        n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL m7x5 zflag: got %b want 0", z); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL m7x5 latency: got %0d want 5", lat); end
        n_cmp++; if (bz !== 1'b1) begin n_bad++; $display("FAIL m7x5 busy window: got %b want 1", bz); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL m7x5 done pulse width: got %b want 0", bus.done); end
        n_cmp++; if (bus.product !== 16'hFFDD) begin n_bad++; $display("FAIL m7x5 product hold: got %h want FFDD", bus.product); end
    endtask

    task automatic test_min_value();
        int lat; logic [2*W-1:0] p; logic z, bz;
        run_op(1'b1, 8'h80, 8'h80, lat, p, z, bz);
        n_cmp++; if (p !== 16'h4000) begin n_bad++; $display("FAIL m128xm128 product: got %h want 4000", p); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL m128xm128 latency: got %0d want 10", lat); end
        run_op(1'b1, 8'h80, 8'h7F, lat, p, z, bz);
        n_cmp++; if (p !== 16'hC080) begin n_bad++; $display("FAIL m128x127 product: got %h want C080", p); end
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL m128x127 latency: got %0d want 9", lat); end
    endtask

    task automatic test_mode();
        int lat; logic [2*W-1:0] p; logic z, bz;
        run_op(1'b0, 8'hFF, 8'hFF, lat, p, z, bz);
        n_cmp++; if (p !== 16'hFE01) begin n_bad++; $display("FAIL u255x255 product: got %h want FE01", p); end
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL u255x255 latency: got %0d want 10", lat); end
        run_op(1'b1, 8'hFF, 8'hFF, lat, p, z, bz);
        n_cmp++; if (p !== 16'h0001) begin n_bad++; $display("FAIL sm1xm1 product: got %h want 0001", p); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sm1xm1 latency: got %0d want 3", lat); end
    endtask

    task automatic test_zero();
        int lat; logic [2*W-1:0] p; logic z, bz;
        run_op(1'b1, 8'h9D, 8'h00, lat, p, z, bz);
        n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL m99x0 product: got %h want 0000", p); end
        n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL m99x0 zflag: got %b want 1", z); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL m99x0 latency: got %0d want 2", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.signed_mode = 1'b0; bus.multiplicand = 8'd3; bus.multiplier = 8'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin bus.multiplicand = 8'd9; bus.multiplier = 8'd9; bus.start = 1'b1; end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin lat = i; break; end
        end
        n_cmp++; if (bus.product !== 16'h000C) begin n_bad++; $display("FAIL busy-ignore product: got %h want 000C", bus.product); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL busy-ignore latency: got %0d want 5", lat); end
        bus.multiplicand = 8'd9; bus.multiplier = 8'd9; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL done-cycle accept busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.product !== 16'h000C) begin n_bad++; $display("FAIL done-cycle old product: got %h want 000C", bus.product); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = i; break; end
        end
        n_cmp++; if (bus.product !== 16'h0051) begin n_bad++; $display("FAIL done-cycle product: got %h want 0051", bus.product); end
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL done-cycle latency: got %0d want 6", lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [2*W-1:0] p; logic z, bz; logic seen;
        bus.signed_mode = 1'b0; bus.multiplicand = 8'd100; bus.multiplier = 8'd100; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.product !== 16'h0000) begin n_bad++; $display("FAIL mid-reset product: got %h want 0000", bus.product); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid-reset busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.zflag !== 1'b1) begin n_bad++; $display("FAIL mid-reset zflag: got %b want 1", bus.zflag); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (bus.done || bus.busy) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid-reset stray activity: got %b want 0", seen); end
        run_op(1'b0, 8'd2, 8'd3, lat, p, z, bz);
        n_cmp++; if (p !== 16'h0006) begin n_bad++; $display("FAIL post-reset product: got %h want 0006", p); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL post-reset latency: got %0d want 4", lat); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        test_reset();
        test_signed_basic();
        test_min_value();
        test_mode();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
